up_debounce: RTL



---
 rtl/fsm_pkg.sv | 29 ++
 rtl/up_debounce_sync_ff.sv | 31 +++
 rtl/up_debounce.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/fsm_pkg.sv
// ----------------------------------------------------------------------------
// fsm_pkg
// Shared types and default constants for the button-conditioning path that
// feeds the 2-bit fsm counter's `up` input.
//   deb_state_t        : debounce FSM state encoding
//   DEB_STABLE_CYCLES  : default consecutive-sample window
//   DEB_SYNC_STAGES    : default synchroniser depth
//   sat_inc()          : saturating increment, used by the glitch counter
// ----------------------------------------------------------------------------
package fsm_pkg;

    typedef enum logic [1:0] {
        LOW_STABLE,
        LOW_TO_HIGH,
        HIGH_STABLE,
        HIGH_TO_LOW
    } deb_state_t;

    localparam int DEB_STABLE_CYCLES = 4;
    localparam int DEB_SYNC_STAGES   = 2;

    // Increment that sticks at all-ones; width is the caller's 32-bit view,
    // the all-ones pattern is passed in so any counter width can use it.
    function automatic logic [31:0] sat_inc(input logic [31:0] v,
                                            input logic [31:0] max_v);
        return (v == max_v) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/up_debounce_sync_ff.sv
// ----------------------------------------------------------------------------
// sync_ff
// Plain flop-chain synchroniser for an asynchronous single-bit level. Nothing
// sits between the stages so every flop has a full cycle to resolve.
//   clk : sampling clock, rising edge
//   rst : synchronous, active-high; clears every stage
//   d   : asynchronous input level
//   q   : synchronised level (last stage)
// ----------------------------------------------------------------------------
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/up_debounce.sv
// ----------------------------------------------------------------------------
// up_debounce
// Synchronises a raw bouncing button level and filters it with a
// consecutive-sample state machine. The clean level drives fsm.up; edge
// pulses and a saturating count of aborted transitions help bring-up.
//   clk        : system clock, rising edge
//   rst        : synchronous, active-high reset
//   btn_in     : raw asynchronous button level (may bounce)
//   up         : debounced level, registered
//   up_rise    : one-cycle pulse in the first cycle up reads 1
//   up_fall    : one-cycle pulse in the first cycle up reads 0
//   bounce_cnt : number of aborted transitions, saturating at all-ones
// ----------------------------------------------------------------------------
module up_debounce
    import fsm_pkg::*;
#(
    parameter int SYNC_STAGES   = DEB_SYNC_STAGES,
    parameter int STABLE_CYCLES = DEB_STABLE_CYCLES,
    parameter int BOUNCE_W      = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                btn_in,
    output logic                up,
    output logic                up_rise,
    output logic                up_fall,
    output logic [BOUNCE_W-1:0] bounce_cnt
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(STABLE_CYCLES);
    localparam logic [BOUNCE_W-1:0] BOUNCE_MAX = '1;

    logic s;

    deb_state_t          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d, cnt_inc;
    logic                up_q, up_d;
    logic                rise_q, rise_d;
    logic                fall_q, fall_d;
    logic [BOUNCE_W-1:0] bounce_q, bounce_d, bounce_inc;

    sync_ff #(
        .STAGES(SYNC_STAGES)
    ) u_sync (
        .clk(clk),
        .rst(rst),
        .d  (btn_in),
        .q  (s)
    );

    // The window counter never exceeds STABLE_CYCLES, so no wrap is possible.
    assign cnt_inc    = cnt_q + CNT_W'(1);
    assign bounce_inc = BOUNCE_W'(sat_inc(32'(bounce_q), 32'(BOUNCE_MAX)));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        up_d     = up_q;
        rise_d   = 1'b0;
        fall_d   = 1'b0;
        bounce_d = bounce_q;
        case (state_q)
            LOW_STABLE: begin
                if (s) begin
                    // A one-sample window is already satisfied by this sample.
                    if (STABLE_CYCLES == 1) begin
                        state_d = HIGH_STABLE;
                        up_d    = 1'b1;
                        rise_d  = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        state_d = LOW_TO_HIGH;
                        cnt_d   = CNT_W'(1);
                    end
                end
            end
            LOW_TO_HIGH: begin
                if (s) begin
                    if (cnt_inc == CNT_DONE) begin
                        state_d = HIGH_STABLE;
                        up_d    = 1'b1;
                        rise_d  = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end else begin
                    state_d  = LOW_STABLE;
                    cnt_d    = '0;
                    bounce_d = bounce_inc;
                end
            end
            HIGH_STABLE: begin
                if (!s) begin
                    if (STABLE_CYCLES == 1) begin
                        state_d = LOW_STABLE;
                        up_d    = 1'b0;
                        fall_d  = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        state_d = HIGH_TO_LOW;
                        cnt_d   = CNT_W'(1);
                    end
                end
            end
            HIGH_TO_LOW: begin
                if (!s) begin
                    if (cnt_inc == CNT_DONE) begin
                        state_d = LOW_STABLE;
                        up_d    = 1'b0;
                        fall_d  = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end else begin
                    state_d  = HIGH_STABLE;
                    cnt_d    = '0;
                    bounce_d = bounce_inc;
                end
            end
            default: begin
                state_d = LOW_STABLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Reset clears up without a fall pulse: pulses only come from the FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= LOW_STABLE;
            cnt_q    <= '0;
            up_q     <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            bounce_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            up_q     <= up_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            bounce_q <= bounce_d;
        end
    end

    assign up         = up_q;
    assign up_rise    = rise_q;
    assign up_fall    = fall_q;
    assign bounce_cnt = bounce_q;

endmodule
